ram_bank_arbiter: RTL

Two-port arbiter and sequencer for the byte-banked program/data memory, which is built from four `single_port_ram_8bit_*` banks. Bank k holds byte lane k of each 32-bit word. The block lets two requesters share the single physical port: port 0 is instruction fetch and port 1 is data/loader. It provides per-cycle arbitration, round-robin fairness, bounded bus locking, byte-enable write steering and 1-cycle read-latency tracking.

---
 rtl/ram_bank_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ram_bank_arbiter.sv
// Two-port arbiter for the byte-banked RAM: one access per cycle, round-robin
// tie-break, bounded lock ownership, per-bank write steering, 1-cycle read tracking.
module ram_bank_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int MAX_LOCK   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_0,
  input  logic                  req_1,
  input  logic                  lock_0,
  input  logic                  lock_1,
  input  logic                  we_0,
  input  logic                  we_1,
  input  logic [3:0]            be_0,
  input  logic [3:0]            be_1,
  input  logic [ADDR_WIDTH-1:0] addr_0,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [31:0]           wdata_0,
  input  logic [31:0]           wdata_1,
  output logic                  ack_0,
  output logic                  ack_1,
  output logic                  rvalid_0,
  output logic                  rvalid_1,
  output logic [31:0]           rdata_0,
  output logic [31:0]           rdata_1,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  output logic [3:0]            mem_we,
  input  logic [31:0]           mem_dout
);
  localparam int         NUM_LANES = 4;
  localparam logic [7:0] LOCK_MAX  = 8'(MAX_LOCK);

  typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1} own_e;

  own_e                  owner_q, owner_d;
  logic [7:0]            lock_cnt_q, lock_cnt_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            rvalid_q;

  logic [1:0]                 req, lock, we;
  logic [1:0][3:0]            be;
  logic [1:0][ADDR_WIDTH-1:0] addr;
  logic [1:0][31:0]           wdata;

  assign req   = {req_1, req_0};
  assign lock  = {lock_1, lock_0};
  assign we    = {we_1, we_0};
  assign be    = {be_1, be_0};
  assign addr  = {addr_1, addr_0};
  assign wdata = {wdata_1, wdata_0};

  logic own_vld, own_idx, oth_idx;
  logic gnt, win, forced;

  assign own_vld = (owner_q != OWN_NONE);
  assign own_idx = (owner_q == OWN_P1);
  assign oth_idx = ~own_idx;

  // Priority: locked owner, forced rotation at the lock bound, single request, tie.
  always_comb begin
    gnt    = 1'b0;
    win    = 1'b0;
    forced = 1'b0;
    if (reset_n && (req != 2'b00)) begin
      gnt = 1'b1;
      if (own_vld && req[own_idx] && lock[own_idx] &&
          ((lock_cnt_q < LOCK_MAX) || !req[oth_idx])) begin
        win = own_idx;
      end else if (own_vld && (lock_cnt_q == LOCK_MAX) && req[oth_idx]) begin
        win    = oth_idx;
        forced = 1'b1;
      end else if (req == 2'b11) begin
        win = ~last_q;
      end else begin
        win = req[1];
      end
    end
  end

  always_comb begin
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    last_d     = last_q;
    if (own_vld && !req[own_idx]) begin
      owner_d    = OWN_NONE;
      lock_cnt_d = 8'd0;
    end
    if (gnt) begin
      last_d = win;
      if (forced) begin
        owner_d    = OWN_NONE;
        lock_cnt_d = 8'd0;
      end else if (lock[win]) begin
        if (own_vld && (own_idx == win)) begin
          lock_cnt_d = (lock_cnt_q < LOCK_MAX) ? lock_cnt_q + 8'd1 : lock_cnt_q;
        end else begin
          // Acquiring grant counts toward the bound.
          owner_d    = win ? OWN_P1 : OWN_P0;
          lock_cnt_d = 8'd1;
        end
      end else if (own_vld && (own_idx == win)) begin
        owner_d    = OWN_NONE;
        lock_cnt_d = 8'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q    <= OWN_NONE;
      lock_cnt_q <= 8'd0;
      last_q     <= 1'b1;
      addr_q     <= '0;
      rvalid_q   <= 2'b00;
    end else begin
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      last_q     <= last_d;
      if (gnt) addr_q <= addr[win];
      rvalid_q   <= {gnt & win & ~we[1], gnt & ~win & ~we[0]};
    end
  end

  assign ack_0    = gnt & ~win;
  assign ack_1    = gnt & win;
  assign rvalid_0 = rvalid_q[0];
  assign rvalid_1 = rvalid_q[1];
  assign rdata_0  = mem_dout;
  assign rdata_1  = mem_dout;
  assign mem_addr = gnt ? addr[win] : addr_q;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign mem_din[8*k +: 8] = wdata[win][8*k +: 8];
    assign mem_we[k]         = gnt & we[win] & be[win][k];
  end
endmodule
